// File: rtl/tx_backoff_ctrl.sv
// tx_backoff_ctrl: half-duplex CSMA/CD transmit sequencer (carrier defer, IFG, jam, backoff, retry/abort)
// Ports:
//   clock_i, reset_i            clock, asynchronous active-high reset
//   tx_req_i                    frame ready (level), sampled only in IDLE
//   carrier_sense_i             medium busy, only looked at while deferring
//   collision_i                 collision detect, only looked at while transmitting
//   tx_done_i                   datapath finished the frame (pulse)
//   tx_start_o / tx_stop_o      datapath start / collision terminate (pulses)
//   jam_o                       datapath sends jam pattern while high
//   backoff_init_o              backoff generator init pulse
//   backoff_retry_count_o       retry code to backoff generator, stable from init to next collision
//   backoff_trigger_i           backoff generator expired
//   tx_ok_o / tx_abort_o        frame sent / frame dropped (pulses)
//   abort_late_o                with tx_abort: 1 = late collision, 0 = excessive collisions
//   attempts_o                  attempts used for current/last frame
// Build option: define LATE_COLL_ABORT_EN to abort (no retry) on collisions past LATE_COLL_CYCLES.
module tx_backoff_ctrl #(
  parameter int MAX_ATTEMPTS     = 16,
  parameter int JAM_CYCLES       = 32,
  parameter int IFG_CYCLES       = 12,
  parameter int LATE_COLL_CYCLES = 64
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tx_req_i,
  input  logic       carrier_sense_i,
  input  logic       collision_i,
  input  logic       tx_done_i,
  output logic       tx_start_o,
  output logic       tx_stop_o,
  output logic       jam_o,
  output logic       backoff_init_o,
  output logic [3:0] backoff_retry_count_o,
  input  logic       backoff_trigger_i,
  output logic       tx_ok_o,
  output logic       tx_abort_o,
  output logic       abort_late_o,
  output logic [4:0] attempts_o
);
  typedef enum logic [2:0] {IDLE, DEFER, TX, JAM, BO_INIT, BO_SETTLE, BO_WAIT, DONE} state_t;
  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);
  localparam logic [4:0]    MAX_ATT  = 5'(MAX_ATTEMPTS);
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 16 || JAM_CYCLES < 1 || IFG_CYCLES < 1 || LATE_COLL_CYCLES < 1) begin : g_bad_param
    $error("tx_backoff_ctrl: parameter out of range");
  end
  state_t        state_q, state_d;
  logic [IW-1:0] ifg_q, ifg_d;
  logic [JW-1:0] jc_q, jc_d;
  logic [4:0]    att_q, att_d;
  logic [3:0]    rc_q, rc_d;
  logic          start_q, start_d, ok_q, ok_d, abort_q, abort_d, al_q, al_d;
  logic          ifg_done, jam_end, late;
  assign ifg_done = state_q == DEFER && !carrier_sense_i && ifg_q == IFG_LAST;
  assign jam_end  = state_q == JAM && jc_q == JAM_LAST;
  always_comb begin
    ifg_d = (state_q == DEFER && !carrier_sense_i) ? ifg_q + 1'b1 : '0;
    jc_d  = (state_q == JAM) ? jc_q + 1'b1 : '0;
  end
`ifdef LATE_COLL_ABORT_EN
  localparam int TW = $clog2(LATE_COLL_CYCLES + 1);
  localparam logic [TW-1:0] LATE_LIM = TW'(LATE_COLL_CYCLES);
  logic [TW-1:0] txc_q, txc_d;
  logic          late_q, late_d;
  // txc is cleared while deferring so it reads 0 on the tx_start cycle
  always_comb begin
    txc_d  = state_q == DEFER ? '0 : (state_q == TX && txc_q != LATE_LIM) ? txc_q + 1'b1 : txc_q;
    late_d = (state_q == TX && collision_i) ? txc_q >= LATE_LIM : late_q;
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      txc_q  <= '0;
      late_q <= 1'b0;
    end else begin
      txc_q  <= txc_d;
      late_q <= late_d;
    end
  assign late = late_q;
`else
  assign late = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    rc_d    = rc_q;
    start_d = 1'b0;
    ok_d    = 1'b0;
    abort_d = 1'b0;
    al_d    = 1'b0;
    case (state_q)
      IDLE: if (tx_req_i) begin
        state_d = DEFER;
        att_d   = 5'd1;
      end
      DEFER: if (ifg_done) begin
        state_d = TX;
        start_d = 1'b1;
      end
      TX: if (collision_i) state_d = JAM;
        else if (tx_done_i) begin
          state_d = DONE;
          ok_d    = 1'b1;
        end
      JAM: if (jam_end) begin
        if (late || att_q == MAX_ATT) begin
          state_d = DONE;
          abort_d = 1'b1;
          al_d    = late;
        end else begin
          state_d = BO_INIT;
          att_d   = att_q + 5'd1;
          rc_d    = att_q > 5'd16 ? 4'hf : 4'(att_q - 5'd1);
        end
      end
      BO_INIT:   state_d = BO_SETTLE;
      // generator trigger is still stale from the previous backoff here
      BO_SETTLE: state_d = BO_WAIT;
      BO_WAIT:   if (backoff_trigger_i) state_d = DEFER;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      ifg_q   <= '0;
      jc_q    <= '0;
      att_q   <= '0;
      rc_q    <= '0;
      start_q <= 1'b0;
      ok_q    <= 1'b0;
      abort_q <= 1'b0;
      al_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ifg_q   <= ifg_d;
      jc_q    <= jc_d;
      att_q   <= att_d;
      rc_q    <= rc_d;
      start_q <= start_d;
      ok_q    <= ok_d;
      abort_q <= abort_d;
      al_q    <= al_d;
    end
  // tx_stop is combinational so the datapath stops in the collision cycle itself
  assign tx_stop_o             = state_q == TX && collision_i;
  assign jam_o                 = state_q == JAM;
  assign backoff_init_o        = state_q == BO_INIT;
  assign tx_start_o            = start_q;
  assign tx_ok_o               = ok_q;
  assign tx_abort_o            = abort_q;
  assign abort_late_o          = al_q;
  assign backoff_retry_count_o = rc_q;
  assign attempts_o            = att_q;
endmodule
